lsu_mem_ctrl: RTL and testbench

- Parametrised load/store unit between the RV32 core and the data RAM.
- Replaces the direct ALU-address/word-only RAM hookup and the combinational writeback mux.
- Adds:
  - byte, halfword and word accesses with byte enables;
  - sign and zero extension on loads;
  - misalignment detection;
  - a configurable RAM read latency, signalled to the core through a valid/ready handshake and a stall line.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_align.sv | 29 ++
 rtl/lsu_mem_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the lsu_mem_ctrl load/store unit.
package lsu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3)
      F3_B, F3_BU: be = 4'b0001 << lo;
      F3_H, F3_HU: be = lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [DATA_W-1:0] word);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h00_0000, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0000, h};
      F3_W:    r = word;
      default: r = {DATA_W{1'b0}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: store byte enables/replication and load lane select/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        acc_funct3,
  input  logic [1:0]        acc_addr_lo,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic [3:0]        acc_be,
  output logic [DATA_W-1:0] acc_lanes,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_addr_lo,
  input  logic [DATA_W-1:0] ld_word,
  output logic [DATA_W-1:0] ld_data
);

  // Store data replicated across every lane the width can occupy
  always_comb begin
    acc_be = byte_en(acc_funct3, acc_addr_lo);
    case (acc_funct3)
      F3_B:    acc_lanes = {4{acc_wdata[7:0]}};
      F3_H:    acc_lanes = {2{acc_wdata[15:0]}};
      F3_W:    acc_lanes = acc_wdata;
      default: acc_lanes = {DATA_W{1'b0}};
    endcase
  end

  assign ld_data = load_ext(ld_funct3, ld_addr_lo, ld_word);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the RV32 core and a data RAM with WAIT_CYC read latency.
// Defining LSU_PERF_CNT_EN adds load/store/error/stall event counters.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned WAIT_CYC  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              CLOCK,
  input  logic              RST_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt,
  output logic [31:0]       err_cnt,
  output logic [31:0]       wait_cnt
`endif
);

  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYC - 1);

  state_e            state_r, next_s;
  logic [2:0]        cnt_r, f3_r;
  logic [1:0]        lo_r;
  logic              err_r;
  logic [DATA_W-1:0] rdata_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [29:0]       off_s;
  logic              fmt_err_s, range_err_s, err_s;
  logic              accept_s, mem_we_s, mem_re_s, stall_s;
  logic [3:0]        be_s;
  logic [DATA_W-1:0] lanes_s, ld_data_s;

  assign off_s       = 30'((req_addr - BASE_ADDR) >> 2);
  assign range_err_s = (off_s >> ADDR_W) != 30'd0;
  assign err_s       = fmt_err_s | range_err_s;

  // Width/alignment legality of the presented request
  always_comb begin
    case (req_funct3)
      F3_B:    fmt_err_s = 1'b0;
      F3_BU:   fmt_err_s = req_we;
      F3_H:    fmt_err_s = req_addr[0];
      F3_HU:   fmt_err_s = req_addr[0] | req_we;
      F3_W:    fmt_err_s = req_addr[1:0] != 2'b00;
      default: fmt_err_s = 1'b1;
    endcase
  end

  lsu_align u_align (
    .acc_funct3 (req_funct3),
    .acc_addr_lo(req_addr[1:0]),
    .acc_wdata  (req_wdata),
    .acc_be     (be_s),
    .acc_lanes  (lanes_s),
    .ld_funct3  (f3_r),
    .ld_addr_lo (lo_r),
    .ld_word    (mem_rdata),
    .ld_data    (ld_data_s)
  );

  // Next-state and strobe decode
  always_comb begin
    next_s   = state_r;
    accept_s = 1'b0;
    mem_we_s = 1'b0;
    mem_re_s = 1'b0;
    stall_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (err_s) begin
            next_s = RESP;
          end else if (req_we) begin
            mem_we_s = 1'b1;
            next_s   = RESP;
          end else begin
            mem_re_s = 1'b1;
            stall_s  = 1'b1;
            next_s   = RD_WAIT;
          end
        end else begin
          next_s = IDLE;
        end
      end
      RD_WAIT: begin
        stall_s = 1'b1;
        if (cnt_r == 3'd0) begin
          next_s = RESP;
        end else begin
          next_s = RD_WAIT;
        end
      end
      RESP:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Access context, latency counter and response data
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      cnt_r      <= 3'd0;
      f3_r       <= 3'd0;
      lo_r       <= 2'd0;
      err_r      <= 1'b0;
      rdata_r    <= {DATA_W{1'b0}};
      mem_addr_r <= {ADDR_W{1'b0}};
    end else begin
      if (mem_we_s | mem_re_s) begin
        mem_addr_r <= off_s[ADDR_W-1:0];
      end
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            f3_r    <= req_funct3;
            lo_r    <= req_addr[1:0];
            err_r   <= err_s;
            rdata_r <= {DATA_W{1'b0}};
            cnt_r   <= CNT_INIT;
          end
        end
        RD_WAIT: begin
          if (cnt_r == 3'd0) begin
            rdata_r <= ld_data_s;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        RESP: begin
          rdata_r <= {DATA_W{1'b0}};
          err_r   <= 1'b0;
        end
        default: begin
          err_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = (state_r == RESP);
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
  assign stall     = stall_s;
  assign mem_we    = mem_we_s;
  assign mem_re    = mem_re_s;
  assign mem_addr  = (mem_we_s | mem_re_s) ? off_s[ADDR_W-1:0] : mem_addr_r;
  assign mem_be    = (mem_we_s | mem_re_s) ? be_s : 4'b0000;
  assign mem_wdata = mem_we_s ? lanes_s : {DATA_W{1'b0}};

`ifdef LSU_PERF_CNT_EN
  logic        we_r;
  logic [31:0] load_cnt_r, store_cnt_r, err_cnt_r, wait_cnt_r;

  // Completion-kind and stall-cycle counters, wrapping modulo 2**32
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      we_r        <= 1'b0;
      load_cnt_r  <= 32'd0;
      store_cnt_r <= 32'd0;
      err_cnt_r   <= 32'd0;
      wait_cnt_r  <= 32'd0;
    end else begin
      if (accept_s) begin
        we_r <= req_we;
      end
      if (rsp_valid & err_r) begin
        err_cnt_r <= err_cnt_r + 32'd1;
      end
      if (rsp_valid & ~err_r & ~we_r) begin
        load_cnt_r <= load_cnt_r + 32'd1;
      end
      if (rsp_valid & ~err_r & we_r) begin
        store_cnt_r <= store_cnt_r + 32'd1;
      end
      if (stall_s) begin
        wait_cnt_r <= wait_cnt_r + 32'd1;
      end
    end
  end

  assign load_cnt  = load_cnt_r;
  assign store_cnt = store_cnt_r;
  assign err_cnt   = err_cnt_r;
  assign wait_cnt  = wait_cnt_r;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: WAIT_CYC=1 and WAIT_CYC=4 instances, table vectors plus scoreboard.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_a [2];
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready_a [2], rsp_valid_a [2], rsp_err_a [2], stall_a [2];
  logic        mem_we_a [2], mem_re_a [2];
  logic [31:0] rsp_rdata_a [2], mem_wdata_a [2], mem_rdata_a [2];
  logic [9:0]  mem_addr_a [2];
  logic [3:0]  mem_be_a [2];
`ifdef LSU_PERF_CNT_EN
  logic [31:0] load_cnt_a [2], store_cnt_a [2], err_cnt_a [2], wait_cnt_a [2];
`endif

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(10), .WAIT_CYC(1), .BASE_ADDR(32'h0000_0000)) dut0 (
    .CLOCK(clk), .RST_n(rst_n), .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a[0]), .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_a[0]),
    .stall(stall_a[0]), .mem_we(mem_we_a[0]), .mem_re(mem_re_a[0]), .mem_addr(mem_addr_a[0]),
    .mem_be(mem_be_a[0]), .mem_wdata(mem_wdata_a[0]), .mem_rdata(mem_rdata_a[0])
`ifdef LSU_PERF_CNT_EN
    , .load_cnt(load_cnt_a[0]), .store_cnt(store_cnt_a[0]), .err_cnt(err_cnt_a[0]),
    .wait_cnt(wait_cnt_a[0])
`endif
  );

  lsu_mem_ctrl #(.ADDR_W(10), .WAIT_CYC(4), .BASE_ADDR(32'h0000_0000)) dut1 (
    .CLOCK(clk), .RST_n(rst_n), .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a[1]), .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_a[1]),
    .stall(stall_a[1]), .mem_we(mem_we_a[1]), .mem_re(mem_re_a[1]), .mem_addr(mem_addr_a[1]),
    .mem_be(mem_be_a[1]), .mem_wdata(mem_wdata_a[1]), .mem_rdata(mem_rdata_a[1])
`ifdef LSU_PERF_CNT_EN
    , .load_cnt(load_cnt_a[1]), .store_cnt(store_cnt_a[1]), .err_cnt(err_cnt_a[1]),
    .wait_cnt(wait_cnt_a[1])
`endif
  );

  // RAM models: byte-enabled writes, reads delivered after 1 resp. 4 cycles, junk otherwise
  logic [31:0] ram [2][1024];
  logic [31:0] pd [2][4];
  logic [3:0]  pv [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we_a[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_a[k][b]) ram[k][mem_addr_a[k]][8*b +: 8] <= mem_wdata_a[k][8*b +: 8];
        end
      end
      pd[k][0] <= ram[k][mem_addr_a[k]];
      pv[k][0] <= mem_re_a[k];
      for (int j = 1; j < 4; j++) begin
        pd[k][j] <= pd[k][j-1];
        pv[k][j] <= pv[k][j-1];
      end
    end
  end

  assign mem_rdata_a[0] = pv[0][0] ? pd[0][0] : 32'hBAD0_BAD0;
  assign mem_rdata_a[1] = pv[1][3] ? pd[1][3] : 32'hBAD0_BAD0;

  typedef struct {
    logic       we;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
    logic [31:0] mwd;
    logic [9:0] madr;
    logic       err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] be, input logic [31:0] mwd,
                              input logic [9:0] madr, input logic err, input logic [31:0] rd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.be = be;
    v.mwd = mwd; v.madr = madr; v.err = err; v.rdata = rd;
    return v;
  endfunction

  // One request on instance s: strobe checks at accept, then latency/stall/response checks
  task automatic issue(input int s, input vec_t v);
    int   n, lat, lat_exp, stalls, readys;
    logic got, is_load;
    rsp_t e;
    n = 0;
    while (!req_ready_a[s] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("ready_timeout", 32'd0, 32'd1);
    req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_valid_a[s] = 1'b1;
    #1;
    is_load = !v.we && !v.err;
    if (v.err) begin
      check("err_no_strobe", 32'({mem_we_a[s], mem_re_a[s]}), 32'd0);
    end else begin
      check("mem_we", 32'(mem_we_a[s]), 32'(v.we));
      check("mem_re", 32'(mem_re_a[s]), 32'(!v.we));
      check("mem_be", 32'(mem_be_a[s]), 32'(v.be));
      check("mem_addr", 32'(mem_addr_a[s]), 32'(v.madr));
      if (v.we) check("mem_wdata", mem_wdata_a[s], v.mwd);
    end
    check("accept_stall", 32'(stall_a[s]), 32'(is_load));
    e.rdata = v.rdata;
    e.err   = v.err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid_a[s] = 1'b0;
    lat_exp = is_load ? ((s == 1) ? 5 : 2) : 1;
    lat = 0; stalls = 0; readys = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      stalls += int'(stall_a[s]);
      readys += int'(req_ready_a[s]);
      if (rsp_valid_a[s]) begin
        got = 1'b1;
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_rdata", rsp_rdata_a[s], e.rdata);
          check("rsp_err", 32'(rsp_err_a[s]), 32'(e.err));
        end
      end
    end
    if (!got) begin
      check("rsp_timeout", 32'd0, 32'd1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
    end else begin
      check("rsp_latency", 32'(lat), 32'(lat_exp));
    end
    check("stall_cycles", 32'(stalls), is_load ? 32'(lat_exp - 1) : 32'd0);
    check("ready_low", 32'(readys), 32'd0);
    @(negedge clk);
    check("rsp_one_pulse", 32'(rsp_valid_a[s]), 32'd0);
    check("ready_back", 32'(req_ready_a[s]), 32'd1);
  endtask

  // Every output except req_ready must read zero
  task automatic check_quiet(input int s);
    check("quiet_ctl", 32'({rsp_valid_a[s], rsp_err_a[s], stall_a[s], mem_we_a[s], mem_re_a[s]}), 32'd0);
    check("quiet_be", 32'(mem_be_a[s]), 32'd0);
    check("quiet_addr", 32'(mem_addr_a[s]), 32'd0);
    check("quiet_rdata", rsp_rdata_a[s], 32'd0);
    check("quiet_wdata", mem_wdata_a[s], 32'd0);
    check("quiet_ready", 32'(req_ready_a[s]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 1024; a++) ram[k][a] = 32'd0;
      pv[k] = 4'd0;
    end
    req_valid_a[0] = 1'b0; req_valid_a[1] = 1'b0;
    req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet(0);
    check_quiet(1);
    rst_n = 1'b1;
    @(negedge clk);

    //             we    f3      addr          wdata         be       mwd           madr     err   rdata
    vecs.push_back(mk(1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 10'd2,   1'b0, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0008, 32'h0,         4'b1111, 32'h0,         10'd2,   1'b0, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0005, 32'h0000_0080, 4'b0010, 32'h8080_8080, 10'd1,   1'b0, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0005, 32'h0,         4'b0010, 32'h0,         10'd1,   1'b0, 32'hFFFF_FF80));
    vecs.push_back(mk(1'b0, 3'b100, 32'h0000_0005, 32'h0,         4'b0010, 32'h0,         10'd1,   1'b0, 32'h0000_0080));
    vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0003, 32'h0,         4'b0000, 32'h0,         10'd0,   1'b1, 32'h0000_0000));
    vecs.push_back(mk(1'b1, 3'b001, 32'h0000_000E, 32'h1234_A5C3, 4'b1100, 32'hA5C3_A5C3, 10'd3,   1'b0, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 3'b001, 32'h0000_000E, 32'h0,         4'b1100, 32'h0,         10'd3,   1'b0, 32'hFFFF_A5C3));
    vecs.push_back(mk(1'b0, 3'b101, 32'h0000_000E, 32'h0,         4'b1100, 32'h0,         10'd3,   1'b0, 32'h0000_A5C3));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0009, 32'h0,         4'b0010, 32'h0,         10'd2,   1'b0, 32'hFFFF_FFBE));
    vecs.push_back(mk(1'b0, 3'b100, 32'h0000_000B, 32'h0,         4'b1000, 32'h0,         10'd2,   1'b0, 32'h0000_00DE));
    vecs.push_back(mk(1'b0, 3'b001, 32'h0000_000A, 32'h0,         4'b1100, 32'h0,         10'd2,   1'b0, 32'hFFFF_DEAD));
    vecs.push_back(mk(1'b0, 3'b101, 32'h0000_0008, 32'h0,         4'b0011, 32'h0,         10'd2,   1'b0, 32'h0000_BEEF));
    vecs.push_back(mk(1'b1, 3'b010, 32'h0000_0FFC, 32'h1234_5678, 4'b1111, 32'h1234_5678, 10'h3FF, 1'b0, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0FFC, 32'h0,         4'b1111, 32'h0,         10'h3FF, 1'b0, 32'h1234_5678));
    vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0007, 32'hFFFF_FF5A, 4'b1000, 32'h5A5A_5A5A, 10'd1,   1'b0, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0006, 32'h0,         4'b0000, 32'h0,         10'd0,   1'b1, 32'h0000_0000));
    vecs.push_back(mk(1'b1, 3'b100, 32'h0000_0004, 32'h0000_0011, 4'b0000, 32'h0,         10'd0,   1'b1, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 3'b011, 32'h0000_0004, 32'h0,         4'b0000, 32'h0,         10'd0,   1'b1, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 3'b110, 32'h0000_0004, 32'h0,         4'b0000, 32'h0,         10'd0,   1'b1, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 3'b111, 32'h0000_0004, 32'h0,         4'b0000, 32'h0,         10'd0,   1'b1, 32'h0000_0000));
    vecs.push_back(mk(1'b1, 3'b010, 32'h0000_1000, 32'h5555_5555, 4'b0000, 32'h0,         10'd0,   1'b1, 32'h0000_0000));
    vecs.push_back(mk(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0,         4'b0000, 32'h0,         10'd0,   1'b1, 32'h0000_0000));

    nv = vecs.size();
    for (int i = 0; i < nv; i++) issue(0, vecs[i]);
    check("mem_addr_hold", 32'(mem_addr_a[0]), 32'd1);

    // Long-latency instance: data arrives only on the 4th cycle after the read strobe
    issue(1, mk(1'b1, 3'b010, 32'h0, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 10'd0, 1'b0, 32'h0));
    issue(1, mk(1'b0, 3'b010, 32'h0, 32'h0,         4'b1111, 32'h0,         10'd0, 1'b0, 32'hCAFE_F00D));

    // Reset while waiting on the RAM aborts the load without a response
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0010; req_wdata = 32'd0;
    req_valid_a[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a[1] = 1'b0;
    @(negedge clk);
    check("rdwait_stall", 32'(stall_a[1]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_quiet(1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int rsp_seen;
      rsp_seen = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        rsp_seen += int'(rsp_valid_a[1]);
      end
      check("abort_no_rsp", 32'(rsp_seen), 32'd0);
      check("abort_ready", 32'(req_ready_a[1]), 32'd1);
    end

`ifdef LSU_PERF_CNT_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("cnt_rst", load_cnt_a[0] | store_cnt_a[0] | err_cnt_a[0] | wait_cnt_a[0], 32'd0);
    issue(0, vecs[0]);
    issue(0, vecs[1]);
    issue(0, vecs[2]);
    issue(0, vecs[3]);
    issue(0, vecs[4]);
    issue(0, vecs[5]);
    check("load_cnt", load_cnt_a[0], 32'd3);
    check("store_cnt", store_cnt_a[0], 32'd2);
    check("err_cnt", err_cnt_a[0], 32'd1);
    check("wait_cnt", wait_cnt_a[0], 32'd6);
`endif

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
